serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//  Bit-serial WIDTH-bit adder built around the team's 1-bit full_adder cell
//  (ports sum, c_out, a, b, c_in). Feeds the cell one operand bit pair per
//  clock, LSB first, from operand shift registers. Holds the carry in a
//  flip-flop between bits. Consumes each sum bit into a result shift register.
//  Trades latency for area in the arithmetic labs.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range 2..32
// PORTS
//  clk    in   1      single clock; all state updates on rising edge
//  rst_n  in   1      synchronous, active-low reset; sampled on rising clk edge
//  start  in   1      request: sample a, b, c_in and begin an add (IDLE only)
//  a      in   WIDTH  operand A, sampled only when start is accepted
//  b      in   WIDTH  operand B, sampled only when start is accepted
//  c_in   in   1      initial carry, sampled only when start is accepted
//  busy   out  1      high while an add is in progress (state ADD)
//  done   out  1      one-cycle pulse: sum/c_out just updated with new result
//  sum    out  WIDTH  result of the last completed add; held until next completion
//  c_out  out  1      carry out of the last completed add; held likewise
// BEHAVIOUR
//  Reset (rst_n=0 at a rising edge): state=IDLE, busy=0, done=0, sum=0, c_out=0.
//   Shift registers, carry flip-flop and bit counter are cleared.
//   Reset asserted mid-add aborts the add: no done pulse, sum/c_out go to 0.
//  States: IDLE, ADD, DONE.
//  IDLE: start=1 at edge E0 -> load sa<=a, sb<=b, carry<=c_in, cnt<=0; go to ADD.
//   start=0 -> remain in IDLE.
//  ADD, each edge:
//   - full_adder inputs are sa[0], sb[0], carry.
//   - carry<=fa.c_out; acc<={fa.sum, acc[WIDTH-1:1]}; sa, sb shift right by 1.
//   - cnt<=cnt+1.
//   - The edge with cnt==WIDTH-1 processes the final MSB and goes to DONE.
//   - ADD therefore spans edges E1..E(WIDTH).
//  DONE: at edge E(WIDTH+1): sum<=acc, c_out<=carry, done<=1 for exactly one
//   cycle; go to IDLE.
//  Timing: done is high in the cycle after edge E(WIDTH+1).
//   Latency from start sample to done visible = WIDTH+1 clocks (9 for WIDTH=8).
//  busy=1 from the cycle after E0 up to and including the DONE-state cycle;
//   busy=0 in the cycle done is high.
//  start is ignored while busy=1; operands are not re-sampled mid-add.
//  Back-to-back: start=1 in the cycle done is high is accepted (state is IDLE).
//   sum/c_out stay at the previous result until the new completion.
//  Arithmetic: {c_out,sum} = a + b + c_in, modulo 2^(WIDTH+1); wraps without error.
//  done and busy are registered outputs (no combinational path from inputs).
// TESTING (WIDTH=8)
//  Reset: rst_n=0 one edge -> busy=0, done=0, sum=8'h00, c_out=0.
//  a=8'h05, b=8'h03, c_in=0, start pulse -> done 9 clocks later; sum=8'h08, c_out=0.
//  a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1 (full carry ripple wrap).
//  a=8'hFF, b=8'hFF, c_in=1 -> sum=8'hFF, c_out=1.
//   Then start=1 in done cycle with a=8'h10, b=8'h20 -> sum=8'h30 nine clocks later.
//  Start re-asserted at cycle 3 of an add with other operands -> ignored;
//   result matches first operands. Exactly one done pulse.
//  rst_n=0 at cycle 4 of an add (a=8'hAA, b=8'h55) -> no done pulse;
//   sum=8'h00, c_out=0, busy=0.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one operand bit pair per clock, LSB first, through a
// single full_adder cell with the carry held in a flip-flop between bits.

module full_adder (
    output logic sum,
    output logic c_out,
    input  logic a,
    input  logic b,
    input  logic c_in
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8  // legal range 2..32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] sa_reg, sa_next;
    logic [WIDTH-1:0] sb_reg, sb_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic             carry_reg, carry_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             c_out_reg, c_out_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic             fa_sum;
    logic             fa_c_out;
    logic [WIDTH-1:0] sa_shift;
    logic [WIDTH-1:0] sb_shift;
    logic [WIDTH-1:0] acc_shift;

    full_adder u_fa (
        .sum   (fa_sum),
        .c_out (fa_c_out),
        .a     (sa_reg[0]),
        .b     (sb_reg[0]),
        .c_in  (carry_reg)
    );

    // Operands drain towards bit 0; each new sum bit enters the result at the MSB,
    // so after WIDTH shifts the first (LSB) sum bit has reached bit 0.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign sa_shift[gi]  = sa_reg[gi+1];
            assign sb_shift[gi]  = sb_reg[gi+1];
            assign acc_shift[gi] = acc_reg[gi+1];
        end
    endgenerate
    assign sa_shift[WIDTH-1]  = 1'b0;
    assign sb_shift[WIDTH-1]  = 1'b0;
    assign acc_shift[WIDTH-1] = fa_sum;

    always_comb begin
        state_next = state_reg;
        sa_next    = sa_reg;
        sb_next    = sb_reg;
        acc_next   = acc_reg;
        carry_next = carry_reg;
        cnt_next   = cnt_reg;
        sum_next   = sum_reg;
        c_out_next = c_out_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    sa_next    = a;
                    sb_next    = b;
                    carry_next = c_in;
                    cnt_next   = '0;
                    state_next = ST_ADD;
                end
            end
            ST_ADD: begin
                carry_next = fa_c_out;
                acc_next   = acc_shift;
                sa_next    = sa_shift;
                sb_next    = sb_shift;
                cnt_next   = cnt_reg + CW'(1);
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                sum_next   = acc_reg;
                c_out_next = carry_reg;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        // Flags are registered from the next state so they line up with it.
        busy_next = (state_next == ST_ADD) || (state_next == ST_DONE);
        done_next = (state_reg == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            sa_reg    <= '0;
            sb_reg    <= '0;
            acc_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            c_out_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sa_reg    <= sa_next;
            sb_reg    <= sb_next;
            acc_reg   <= acc_next;
            carry_reg <= carry_next;
            cnt_reg   <= cnt_next;
            sum_reg   <= sum_next;
            c_out_reg <= c_out_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign busy  = busy_reg;
    assign done  = done_reg;
    assign sum   = sum_reg;
    assign c_out = c_out_reg;

endmodule
